// File: rtl/lfsr_packet_crypt.sv
// lfsr_packet_crypt: LFSR-keyed packet encrypt/decrypt; preamble length, taps and seed come from a config ROM.
// Optional LFSR_CRYPT_PREAMBLE_CHECK_EN flags decrypt preamble bytes that do not decode to PRE_CHAR.
module lfsr_packet_crypt #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int LFSR_W = 5,
    parameter logic [DW-1:0] PRE_CHAR = 'h7E
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          encRqst,
    input  logic          mode,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          validIn,
    input  logic [DW-1:0] plainByte,
    input  logic          lastIn,
    output logic          readyIn,
    output logic [DW-1:0] encryptByte,
    output logic          validOut,
    input  logic          readyOut,
    output logic          done,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, RD_LEN, RD_TAPS, RD_SEED, PREAMBLE, PAYLOAD, FLUSH} state_t;
    state_t state;
    logic decMode;
    logic [DW-1:0] preLen, preCnt, key, mixed;
    logic [AW-1:0] byteCnt;
    logic [LFSR_W-1:0] taps, lfsr, lfsrNext, seed;
    logic slotFree, inXfer, genXfer, step;
    assign key = {{(DW-LFSR_W){1'b0}}, lfsr};
    assign mixed = plainByte ^ key;
    assign seed = rom_data[LFSR_W-1:0];
    assign lfsrNext = {lfsr[LFSR_W-2:0], ^(lfsr & taps)};
    assign slotFree = !validOut || readyOut;
    assign readyIn = slotFree && (state == PAYLOAD || (state == PREAMBLE && decMode));
    assign inXfer = validIn && readyIn;
    // encrypt preamble bytes are generated internally whenever the output slot is free
    assign genXfer = slotFree && state == PREAMBLE && !decMode;
    assign step = inXfer || genXfer;
    assign rom_addr = state == RD_TAPS ? AW'(1) : state == RD_SEED ? AW'(2) : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            decMode <= 1'b0;
            preLen <= '0;
            preCnt <= '0;
            byteCnt <= '0;
            taps <= '0;
            lfsr <= '0;
            validOut <= 1'b0;
            encryptByte <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (step) lfsr <= lfsrNext;
            if (genXfer || (inXfer && state == PAYLOAD)) begin
                validOut <= 1'b1;
                encryptByte <= genXfer ? PRE_CHAR ^ key : {!decMode, mixed[DW-2:0]};
            end else if (readyOut) validOut <= 1'b0;
            case (state)
                IDLE: if (encRqst) begin
                    state <= RD_LEN;
                    decMode <= mode;
                end
                RD_LEN: begin
                    preLen <= rom_data;
                    state <= RD_TAPS;
                end
                RD_TAPS: begin
                    taps <= rom_data[LFSR_W-1:0];
                    state <= RD_SEED;
                end
                RD_SEED: begin
                    lfsr <= seed == '0 ? LFSR_W'(1) : seed;
                    preCnt <= '0;
                    byteCnt <= '0;
                    state <= preLen != '0 ? PREAMBLE : PAYLOAD;
                end
                PREAMBLE: if (step) begin
                    preCnt <= preCnt + DW'(1);
                    if (preCnt + DW'(1) == preLen) state <= PAYLOAD;
                end
                PAYLOAD: if (inXfer) begin
                    if (byteCnt != '1) byteCnt <= byteCnt + AW'(1);
                    if (lastIn) state <= FLUSH;
                end
                FLUSH: if (!validOut) begin
                    done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef LFSR_CRYPT_PREAMBLE_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (state == IDLE && encRqst) err <= 1'b0;
        else if (inXfer && state == PREAMBLE && mixed != PRE_CHAR) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_packet_crypt.sv
// tb_lfsr_packet_crypt: randomized packets against a queue-based keystream model of lfsr_packet_crypt.
module tb_lfsr_packet_crypt;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic encRqst = 1'b0, mode = 1'b0, validIn = 1'b0, lastIn = 1'b0, readyOut = 1'b0;
    logic [7:0] plainByte = '0;
    logic [7:0] rom_addr, rom_data, encryptByte;
    logic readyIn, validOut, done, err;
    logic [7:0] romLen, romTaps, romSeed;
    int nVec = 0, nBad = 0;

    lfsr_packet_crypt dut (
        .clk(clk), .rst(rst), .encRqst(encRqst), .mode(mode),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .validIn(validIn), .plainByte(plainByte), .lastIn(lastIn), .readyIn(readyIn),
        .encryptByte(encryptByte), .validOut(validOut), .readyOut(readyOut),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;
    assign rom_data = rom_addr == 8'd0 ? romLen : rom_addr == 8'd1 ? romTaps : romSeed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nVec++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic resetChecks(input string tag);
        check({tag, "_validOut"}, validOut, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_readyIn"}, readyIn, 0);
        check({tag, "_encryptByte"}, encryptByte, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    task automatic runPacket(input bit dec, input int len, input int tp, input int sd, input int nPay,
                             input int firstByte, input int rdyPct, input int stallAt, input bit corrupt,
                             input int abortAt);
        int keys[$], plain[$], cipher[$], ins[$], exp[$];
        int l, ii, cyc, gotOut, expErr;
        bit sawDone, prevStall, fired;
        logic [7:0] prevByte;
        // keystream: Fibonacci shift-left, feedback = parity of (state & taps), zero seed becomes 1
        l = (sd % 32) == 0 ? 1 : sd % 32;
        for (int k = 0; k < len + nPay; k++) begin
            keys.push_back(l);
            l = ((l * 2) + ($countones(l & tp & 31) % 2)) % 32;
        end
        for (int k = 0; k < len; k++) cipher.push_back(8'h7E ^ keys[k]);
        for (int j = 0; j < nPay; j++) begin
            plain.push_back((j == 0 && firstByte >= 0) ? firstByte : int'($urandom_range(255)));
            cipher.push_back((plain[j] ^ keys[len + j]) | 8'h80);
        end
        if (dec) begin
            ins = cipher;
            if (corrupt && len > 0) ins[0] = ins[0] ^ 8'h01;
            foreach (plain[j]) exp.push_back(plain[j] & 8'h7F);
        end else begin
            ins = plain;
            exp = cipher;
        end
`ifdef LFSR_CRYPT_PREAMBLE_CHECK_EN
        expErr = (dec && corrupt && len > 0) ? 1 : 0;
`else
        expErr = 0;
`endif
        romLen = 8'(len);
        romTaps = 8'(tp);
        romSeed = 8'(sd);
        @(posedge clk); #1;
        mode = dec;
        encRqst = 1'b1;
        @(posedge clk); #1;
        encRqst = 1'b0;
        ii = 0; cyc = 0; gotOut = 0; sawDone = 0; prevStall = 0; prevByte = '0;
        while (!sawDone && cyc < 2000 && cyc != abortAt) begin
            validIn = ii < ins.size() && $urandom_range(99) < 80;
            plainByte = ii < ins.size() ? 8'(ins[ii]) : 8'($urandom);
            lastIn = ii == ins.size() - 1;
            readyOut = (cyc >= stallAt && cyc < stallAt + 5) ? 1'b0 : $urandom_range(99) < rdyPct;
            mode = 1'($urandom_range(1));
            encRqst = ii < ins.size() && $urandom_range(9) == 0;
            @(negedge clk);
            if (prevStall) begin
                check("stall_byte", encryptByte, prevByte);
                check("stall_valid", validOut, 1);
            end
            if (validOut && !readyOut) check("stall_readyIn", readyIn, 0);
            if (validOut && readyOut) begin
                if (gotOut < exp.size()) check($sformatf("out[%0d]", gotOut), encryptByte, exp[gotOut]);
                gotOut++;
            end
            prevStall = validOut && !readyOut;
            prevByte = encryptByte;
            fired = validIn && readyIn;
            if (done) sawDone = 1;
            @(posedge clk); #1;
            if (fired) ii++;
            cyc++;
        end
        if (cyc == abortAt) begin
            rst = 1'b0;
            validIn = 1'b0;
            encRqst = 1'b0;
            @(negedge clk);
            resetChecks("abort");
            @(posedge clk); #1;
            rst = 1'b1;
            repeat (10) begin
                @(negedge clk);
                check("abort_no_done", done, 0);
            end
            return;
        end
        check("done_seen", sawDone, 1);
        check("in_count", ii, ins.size());
        check("out_count", gotOut, exp.size());
        check("err_at_done", err, expErr);
        @(posedge clk); #1;
        validIn = 1'b0;
        encRqst = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("err_after_done", err, expErr);
    endtask

    initial begin
        romLen = 0; romTaps = 0; romSeed = 0;
        repeat (2) @(negedge clk);
        resetChecks("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        // known ROM {2,0x14,0x01}: preamble 7F,7C then payload keyed from 0x04
        runPacket(0, 2, 8'h14, 8'h01, 6, -1, 100, -1, 0, -1);
        // no preamble, 0x41 with seed 1 -> C0
        runPacket(0, 0, 8'h14, 8'h01, 1, 8'h41, 100, -1, 0, -1);
        runPacket(1, 2, 8'h14, 8'h01, 6, -1, 70, -1, 0, -1);
        runPacket(0, 1, 8'h12, 8'h0B, 10, -1, 100, 8, 0, -1);
        runPacket(0, 3, 8'h1E, 8'h00, 4, -1, 90, -1, 0, -1);
        runPacket(0, 1, 8'h09, 8'h05, 30, -1, 100, -1, 0, 15);
        runPacket(1, 3, 8'h0D, 8'h13, 5, -1, 80, 6, 1, -1);
        runPacket(1, 2, 8'h14, 8'h01, 4, -1, 100, -1, 0, -1);
        for (int p = 0; p < 8; p++)
            runPacket(1'($urandom_range(1)), $urandom_range(4), $urandom_range(31), $urandom_range(3) == 0 ? 0 : $urandom_range(255),
                      $urandom_range(1, 12), -1, $urandom_range(50, 100), $urandom_range(3) == 0 ? 6 : -1,
                      1'($urandom_range(1)), -1);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule

// File: doc/lfsr_packet_crypt.md
LFSR_PACKET_CRYPT -- requirements
Module: lfsr_packet_crypt

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DW, 8, data byte width
- AW, 8, byte-count / ROM address width
- LFSR_W, 5, LFSR width (2 <= LFSR_W < DW)
- PRE_CHAR, 8'h7E, preamble character
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock
- rst, in, 1, asynchronous active-low reset
- encRqst, in, 1, start pulse
- mode, in, 1, 0=encrypt, 1=decrypt; sampled at encRqst
- rom_addr, out, AW, config ROM address (combinational-read ROM)
- rom_data, in, DW, config ROM data, same cycle
- validIn, in, 1, input byte valid
- plainByte, in, DW, input byte
- lastIn, in, 1, final byte of packet, qualified by validIn
- readyIn, out, 1, block accepts input byte
- encryptByte, out, DW, output byte
- validOut, out, 1, output byte valid
- readyOut, in, 1, downstream accepts output byte
- done, out, 1, one-cycle packet-complete pulse
- err, out, 1, sticky preamble-mismatch flag

Function
REQ-003 The state machine SHALL use states IDLE, RD_LEN, RD_TAPS, RD_SEED, PREAMBLE, PAYLOAD, FLUSH; any unused encoding SHALL return to IDLE.
REQ-004 IDLE -> RD_LEN on encRqst; encRqst outside IDLE SHALL be ignored.
REQ-005 RD_LEN, RD_TAPS, RD_SEED SHALL drive rom_addr = 0, 1, 2 respectively and capture rom_data into pre_len, taps[LFSR_W-1:0], and lfsr, one cycle each.
REQ-006 A zero seed SHALL load lfsr = 1 to avoid lock-up.
REQ-007 LFSR advance: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & taps)}; it SHALL advance exactly once per byte transferred in PREAMBLE or PAYLOAD, never otherwise.
REQ-008 key = lfsr zero-extended to DW bits.
REQ-009 RD_SEED -> PREAMBLE if pre_len != 0, otherwise -> PAYLOAD.
REQ-010 Encrypt PREAMBLE: the block SHALL self-generate pre_len bytes of PRE_CHAR ^ key with readyIn = 0.
REQ-011 Decrypt PREAMBLE: the block SHALL consume pre_len input bytes and emit no output for them.
REQ-012 Encrypt PAYLOAD: output byte = (plainByte ^ key) with bit DW-1 forced to 1.
REQ-013 Decrypt PAYLOAD: output byte = (plainByte ^ key) with bit DW-1 forced to 0.
REQ-014 Output SHALL be a single register stage with readyIn = !validOut || readyOut; an input byte transfers when validIn && readyIn; latency from transfer to validOut is 1 cycle.
REQ-015 validOut and encryptByte SHALL be held stable while validOut && !readyOut.
REQ-016 A preamble counter SHALL count transferred preamble bytes; PREAMBLE -> PAYLOAD when the count reaches pre_len.
REQ-017 PAYLOAD byte counter (AW bits) SHALL saturate at 2**AW-1.
REQ-018 PAYLOAD -> FLUSH on transfer of a byte with lastIn; lastIn during PREAMBLE SHALL be ignored.
REQ-019 FLUSH SHALL wait until the output register is empty, then pulse done for one cycle and go to IDLE.
REQ-020 Simultaneous output drain and new load in the same cycle SHALL preserve throughput of one byte per cycle.

Reset
REQ-021 On rst low, asynchronously: state = IDLE; validOut, done, err, readyIn = 0; encryptByte, rom_addr, lfsr, taps, pre_len, and all counters = 0.
REQ-022 Reset mid-packet SHALL abort without emitting done; the first packet after reset SHALL rerun the ROM reads.

Configuration
REQ-023 Macro LFSR_CRYPT_PREAMBLE_CHECK_EN defined: in decrypt PREAMBLE, each input byte ^ key != PRE_CHAR SHALL set err (sticky until the next encRqst accepted in IDLE, or reset); err has no other effect on the datapath.
REQ-024 Macro LFSR_CRYPT_PREAMBLE_CHECK_EN undefined: the comparison logic SHALL be absent and err SHALL be tied to 0.

Verification
REQ-025 Encrypt, ROM = {2, 0x14, 0x01}, readyOut = 1 -> outputs 0x7F then 0x7C, then payload starting with key 0x04.
REQ-026 Encrypt, pre_len = 0, plainByte = 0x41 with lastIn, seed 0x01 -> output 0xC0, then a done pulse after validOut drains.
REQ-027 Decrypt the REQ-025 ciphertext -> original payload recovered with bit 7 = 0, no preamble bytes output, err = 0.
REQ-028 readyOut held low for 5 cycles mid-payload -> encryptByte stable, readyIn = 0, LFSR frozen, no bytes lost or duplicated.
REQ-029 Seed 0x00 -> first preamble byte = 0x7F; rst asserted mid-PAYLOAD -> all outputs 0, no done pulse.
REQ-030 With LFSR_CRYPT_PREAMBLE_CHECK_EN defined: decrypt with a corrupted preamble byte -> err = 1 and held through done.
